// File: rtl/laser_host.sv
// Host-side driver and scorer for the two-circle laser coverage engine.
// Software loads a target-point buffer while the block is idle. START streams
// the points to the engine and waits for the engine's centers. The buffer is
// then rescanned to count the targets covered by either radius-4 circle, and
// the score is reported with a one-cycle strobe.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | buffer writable, waiting for START
// S_SEND   | one buffer point per cycle on x_o/y_o with pt_valid_o high
// S_WAIT   | waiting for engine DONE, timeout counter running
// S_SCORE  | one buffer point per cycle tested against both circles
// S_REPORT | res_valid_o high for one cycle, then back to idle
module laser_host #(
  parameter int NUM_PTS     = 40,
  parameter int RADIUS_SQ   = 16,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       wr_en_i,
  input  logic [5:0] wr_addr_i,
  input  logic [3:0] wr_x_i,
  input  logic [3:0] wr_y_i,
  input  logic       start_i,
  output logic       busy_o,
  output logic [3:0] x_o,
  output logic [3:0] y_o,
  output logic       pt_valid_o,
  input  logic       done_i,
  input  logic [3:0] c1x_i,
  input  logic [3:0] c1y_i,
  input  logic [3:0] c2x_i,
  input  logic [3:0] c2y_i,
  output logic       res_valid_o,
  output logic [5:0] score_o,
  output logic [3:0] res_c1x_o,
  output logic [3:0] res_c1y_o,
  output logic [3:0] res_c2x_o,
  output logic [3:0] res_c2y_o,
  output logic       timeout_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [5:0] LAST_IDX = 6'(NUM_PTS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_SCORE, S_REPORT} state_t;

  state_t           state_q, state_d;
  logic [7:0]       pts_q [NUM_PTS];
  logic [5:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       x_q, x_d, y_q, y_d;
  logic             pv_q, pv_d;
  logic             rv_q, rv_d;
  logic [5:0]       score_q, score_d;
  logic [15:0]      res_q, res_d;
  logic             to_q, to_d;
  logic             wr_ok;
  logic [7:0]       cur_pt;
  logic             hit;

  // Squared distance using 5-bit signed deltas; operands are widened before
  // squaring so the product keeps its sign-correct magnitude (max 225).
  function automatic logic [8:0] dist_sq(input logic [3:0] px, input logic [3:0] py,
                                         input logic [3:0] cx, input logic [3:0] cy);
    logic signed [4:0] dx, dy;
    logic signed [9:0] ex, ey, sx, sy;
    dx = $signed({1'b0, px}) - $signed({1'b0, cx});
    dy = $signed({1'b0, py}) - $signed({1'b0, cy});
    ex = 10'(dx);
    ey = 10'(dy);
    sx = ex * ex;
    sy = ey * ey;
    return sx[8:0] + sy[8:0];
  endfunction

  assign wr_ok  = wr_en_i && (state_q == S_IDLE) && (wr_addr_i < 6'(NUM_PTS));
  assign cur_pt = pts_q[idx_q];
  assign hit    = (dist_sq(cur_pt[3:0], cur_pt[7:4], res_q[3:0], res_q[7:4]) <= 9'(RADIUS_SQ)) ||
                  (dist_sq(cur_pt[3:0], cur_pt[7:4], res_q[11:8], res_q[15:12]) <= 9'(RADIUS_SQ));

  // Point buffer: writable only while idle, cleared by reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NUM_PTS; i++) pts_q[i] <= '0;
    end else if (wr_ok) begin
      pts_q[wr_addr_i] <= {wr_y_i, wr_x_i};
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      pv_q    <= 1'b0;
      rv_q    <= 1'b0;
      score_q <= '0;
      res_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      pv_q    <= pv_d;
      rv_q    <= rv_d;
      score_q <= score_d;
      res_q   <= res_d;
      to_q    <= to_d;
    end
  end

  // Next-state and datapath decisions.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    x_d     = '0;
    y_d     = '0;
    pv_d    = 1'b0;
    rv_d    = 1'b0;
    score_d = score_q;
    res_d   = res_q;
    to_d    = to_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_SEND;
          idx_d   = '0;
          pv_d    = 1'b1;
          // A write to entry 0 in the START cycle must show up as the first point.
          if (wr_ok && (wr_addr_i == 6'd0)) begin
            x_d = wr_x_i;
            y_d = wr_y_i;
          end else begin
            x_d = pts_q[0][3:0];
            y_d = pts_q[0][7:4];
          end
          score_d = '0;
          res_d   = '0;
          to_d    = 1'b0;
        end
      end
      S_SEND: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_WAIT;
          idx_d   = '0;
          cnt_d   = '0;
        end else begin
          idx_d = idx_q + 6'd1;
          x_d   = pts_q[idx_d][3:0];
          y_d   = pts_q[idx_d][7:4];
          pv_d  = 1'b1;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (done_i) begin
          state_d = S_SCORE;
          idx_d   = '0;
          res_d   = {c2y_i, c2x_i, c1y_i, c1x_i};
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_REPORT;
          rv_d    = 1'b1;
          to_d    = 1'b1;
          score_d = '0;
          res_d   = '0;
        end
      end
      S_SCORE: begin
        score_d = score_q + {5'd0, hit};
        if (idx_q == LAST_IDX) begin
          state_d = S_REPORT;
          idx_d   = '0;
          rv_d    = 1'b1;
        end else begin
          idx_d = idx_q + 6'd1;
        end
      end
      S_REPORT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy_o      = (state_q != S_IDLE);
  assign x_o         = x_q;
  assign y_o         = y_q;
  assign pt_valid_o  = pv_q;
  assign res_valid_o = rv_q;
  assign score_o     = score_q;
  assign res_c1x_o   = res_q[3:0];
  assign res_c1y_o   = res_q[7:4];
  assign res_c2x_o   = res_q[11:8];
  assign res_c2y_o   = res_q[15:12];
  assign timeout_o   = to_q;

endmodule

// File: tb/tb_laser_host.sv
// Bench for laser_host: directed frames from the test plan plus randomized
// frames, all checked against a buffer/score model kept in the bench.
module tb_laser_host;

  localparam int NUM_PTS     = 40;
  localparam int TIMEOUT_CYC = 20000;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic       wr_en_i;
  logic [5:0] wr_addr_i;
  logic [3:0] wr_x_i, wr_y_i;
  logic       start_i;
  logic       busy_o;
  logic [3:0] x_o, y_o;
  logic       pt_valid_o;
  logic       done_i;
  logic [3:0] c1x_i, c1y_i, c2x_i, c2y_i;
  logic       res_valid_o;
  logic [5:0] score_o;
  logic [3:0] res_c1x_o, res_c1y_o, res_c2x_o, res_c2y_o;
  logic       timeout_o;

  laser_host dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
    .wr_x_i(wr_x_i), .wr_y_i(wr_y_i), .start_i(start_i), .busy_o(busy_o),
    .x_o(x_o), .y_o(y_o), .pt_valid_o(pt_valid_o), .done_i(done_i),
    .c1x_i(c1x_i), .c1y_i(c1y_i), .c2x_i(c2x_i), .c2y_i(c2y_i),
    .res_valid_o(res_valid_o), .score_o(score_o),
    .res_c1x_o(res_c1x_o), .res_c1y_o(res_c1y_o), .res_c2x_o(res_c2x_o), .res_c2y_o(res_c2y_o),
    .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;
  logic [3:0] mx [NUM_PTS];
  logic [3:0] my [NUM_PTS];

  function automatic int model_score(input logic [3:0] ax, input logic [3:0] ay,
                                     input logic [3:0] bx, input logic [3:0] by);
    int n = 0;
    for (int i = 0; i < NUM_PTS; i++) begin
      int d1 = (int'(mx[i]) - int'(ax)) ** 2 + (int'(my[i]) - int'(ay)) ** 2;
      int d2 = (int'(mx[i]) - int'(bx)) ** 2 + (int'(my[i]) - int'(by)) ** 2;
      if (d1 <= 16 || d2 <= 16) n++;
    end
    return n;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NUM_PTS; i++) begin mx[i] = '0; my[i] = '0; end
  endtask

  task automatic load_pt(input logic [5:0] a, input logic [3:0] px, input logic [3:0] py);
    @(negedge clk_i);
    wr_en_i = 1'b1; wr_addr_i = a; wr_x_i = px; wr_y_i = py;
    if (a < NUM_PTS) begin mx[a] = px; my[a] = py; end
    @(negedge clk_i);
    wr_en_i = 1'b0;
  endtask

  // One full frame: START, stream check, optional DONE, result check.
  task automatic run_frame(input bit give_done, input int done_dly,
                           input logic [3:0] ax, input logic [3:0] ay,
                           input logic [3:0] bx, input logic [3:0] by,
                           input bit disturb, input bit sw,
                           input logic [5:0] sw_addr, input logic [7:0] sw_data);
    int exp_score, cyc, exp_lat;
    bit seen;
    logic [5:0] exp_s;
    logic [15:0] exp_res;
    @(negedge clk_i);
    start_i = 1'b1;
    if (sw) begin
      wr_en_i = 1'b1; wr_addr_i = sw_addr; wr_x_i = sw_data[3:0]; wr_y_i = sw_data[7:4];
      if (sw_addr < NUM_PTS) begin mx[sw_addr] = sw_data[3:0]; my[sw_addr] = sw_data[7:4]; end
    end
    exp_score = model_score(ax, ay, bx, by);
    @(negedge clk_i);
    start_i = 1'b0; wr_en_i = 1'b0;
    for (int i = 0; i < NUM_PTS; i++) begin
      total++;
      if (pt_valid_o !== 1'b1 || busy_o !== 1'b1 || x_o !== mx[i] || y_o !== my[i]) begin
        bad++;
        $display("FAIL stream[%0d]: got pv=%b busy=%b x=%0d y=%0d, want pv=1 busy=1 x=%0d y=%0d",
                 i, pt_valid_o, busy_o, x_o, y_o, mx[i], my[i]);
      end
      if (i == 0) begin
        total++;
        if ({score_o, res_c1x_o, res_c1y_o, res_c2x_o, res_c2y_o, timeout_o, res_valid_o} !== '0) begin
          bad++;
          $display("FAIL clear_on_send: got score=%0d res=%h%h%h%h to=%b rv=%b, want all 0",
                   score_o, res_c1x_o, res_c1y_o, res_c2x_o, res_c2y_o, timeout_o, res_valid_o);
        end
      end
      if (disturb) begin
        wr_en_i = (i >= 8 && i < 14);
        wr_addr_i = 6'($urandom_range(0, 39));
        wr_x_i = 4'($urandom); wr_y_i = 4'($urandom);
        start_i = (i == 15);
        done_i = (i == 20);
        c1x_i = 4'($urandom); c1y_i = 4'($urandom); c2x_i = 4'($urandom); c2y_i = 4'($urandom);
      end
      @(negedge clk_i);
    end
    wr_en_i = 1'b0; start_i = 1'b0; done_i = 1'b0;
    total++;
    if (pt_valid_o !== 1'b0 || x_o !== 4'd0 || y_o !== 4'd0 || busy_o !== 1'b1) begin
      bad++;
      $display("FAIL stream_end: got pv=%b x=%0d y=%0d busy=%b, want pv=0 x=0 y=0 busy=1",
               pt_valid_o, x_o, y_o, busy_o);
    end
    cyc = 0;
    if (give_done) begin
      repeat (done_dly) begin @(negedge clk_i); cyc++; end
      done_i = 1'b1; c1x_i = ax; c1y_i = ay; c2x_i = bx; c2y_i = by;
      @(negedge clk_i);
      cyc++;
      done_i = 1'b0;
      c1x_i = 4'($urandom); c1y_i = 4'($urandom); c2x_i = 4'($urandom); c2y_i = 4'($urandom);
      exp_lat = done_dly + 41;
      exp_s = 6'(exp_score);
      exp_res = {ax, ay, bx, by};
    end else begin
      exp_lat = TIMEOUT_CYC;
      exp_s = 6'd0;
      exp_res = 16'd0;
    end
    seen = 1'b0;
    while (!seen && cyc < exp_lat + 100) begin
      if (res_valid_o === 1'b1) seen = 1'b1;
      else begin @(negedge clk_i); cyc++; end
    end
    total++;
    if (!seen || cyc != exp_lat) begin
      bad++;
      $display("FAIL res_latency: got seen=%0d at cycle %0d, want cycle %0d", seen, cyc, exp_lat);
    end
    if (seen) begin
      total++;
      if (score_o !== exp_s || timeout_o !== !give_done || busy_o !== 1'b1 ||
          {res_c1x_o, res_c1y_o, res_c2x_o, res_c2y_o} !== exp_res) begin
        bad++;
        $display("FAIL result: got score=%0d to=%b busy=%b res=%h%h%h%h, want score=%0d to=%b busy=1 res=%h",
                 score_o, timeout_o, busy_o, res_c1x_o, res_c1y_o, res_c2x_o, res_c2y_o,
                 exp_s, !give_done, exp_res);
      end
      @(negedge clk_i);
      total++;
      if (res_valid_o !== 1'b0 || busy_o !== 1'b0 || score_o !== exp_s ||
          {res_c1x_o, res_c1y_o, res_c2x_o, res_c2y_o} !== exp_res) begin
        bad++;
        $display("FAIL result_hold: got rv=%b busy=%b score=%0d res=%h%h%h%h, want rv=0 busy=0 score=%0d res=%h",
                 res_valid_o, busy_o, score_o, res_c1x_o, res_c1y_o, res_c2x_o, res_c2y_o, exp_s, exp_res);
      end
    end
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0; wr_en_i = 1'b0; wr_addr_i = '0; wr_x_i = '0; wr_y_i = '0;
    start_i = 1'b0; done_i = 1'b0; c1x_i = '0; c1y_i = '0; c2x_i = '0; c2y_i = '0;
    model_clear();
    repeat (3) @(negedge clk_i);
    total++;
    if ({busy_o, x_o, y_o, pt_valid_o, res_valid_o, score_o, res_c1x_o, res_c1y_o,
         res_c2x_o, res_c2y_o, timeout_o} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b pv=%b rv=%b score=%0d to=%b, want all 0",
               busy_o, pt_valid_o, res_valid_o, score_o, timeout_o);
    end
    rst_n_i = 1'b1;
    @(negedge clk_i);
    total++;
    if ({busy_o, pt_valid_o, res_valid_o, score_o, timeout_o} !== '0) begin
      bad++;
      $display("FAIL reset_release: got busy=%b pv=%b rv=%b score=%0d to=%b, want all 0",
               busy_o, pt_valid_o, res_valid_o, score_o, timeout_o);
    end
  endtask

  task automatic test_stream();
    load_pt(6'd5, 4'd7, 4'd9);
    run_frame(1'b1, 0, 4'd7, 4'd9, 4'd0, 4'd0, 1'b0, 1'b0, 6'd0, 8'd0);
  endtask

  task automatic test_cluster();
    for (int i = 0; i < NUM_PTS; i++) begin
      if (i < 25) load_pt(6'(i), 4'(1 + i % 5), 4'(1 + i / 5));
      else        load_pt(6'(i), 4'd12, 4'd12);
    end
    run_frame(1'b1, 2, 4'd3, 4'd3, 4'd12, 4'd12, 1'b0, 1'b0, 6'd0, 8'd0);
  endtask

  task automatic test_boundary();
    for (int i = 0; i < NUM_PTS; i++) begin
      if (i < 5)       load_pt(6'(i), 4'd0, 4'd0);
      else if (i < 10) load_pt(6'(i), 4'd4, 4'd0);
      else             load_pt(6'(i), 4'd15, 4'd15);
    end
    run_frame(1'b1, 1, 4'd0, 4'd0, 4'd4, 4'd0, 1'b0, 1'b0, 6'd0, 8'd0);
    load_pt(6'd10, 4'd4, 4'd1);
    run_frame(1'b1, 0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 6'd0, 8'd0);
  endtask

  task automatic test_timeout();
    run_frame(1'b0, 0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 6'd0, 8'd0);
  endtask

  task automatic test_disturb();
    for (int i = 0; i < NUM_PTS; i++) load_pt(6'(i), 4'($urandom), 4'($urandom));
    run_frame(1'b1, 3, mx[7], my[7], mx[30], my[30], 1'b1, 1'b0, 6'd0, 8'd0);
    run_frame(1'b1, 0, mx[2], my[2], 4'd8, 4'd8, 1'b0, 1'b0, 6'd0, 8'd0);
  endtask

  task automatic test_start_write();
    run_frame(1'b1, 1, 4'd3, 4'd4, mx[1], my[1], 1'b0, 1'b1, 6'd0, 8'h5a);
    run_frame(1'b1, 0, 4'd3, 4'd4, mx[1], my[1], 1'b0, 1'b1, 6'd44, 8'hff);
  endtask

  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      int r1, r2;
      repeat ($urandom_range(10, 25))
        load_pt(6'($urandom_range(0, 47)), 4'($urandom), 4'($urandom));
      r1 = $urandom_range(0, NUM_PTS - 1);
      r2 = $urandom_range(0, NUM_PTS - 1);
      run_frame(1'b1, $urandom_range(0, 6),
                mx[r1] + 4'($urandom_range(0, 2)), my[r1], mx[r2], my[r2] + 4'($urandom_range(0, 2)),
                1'b0, 1'b0, 6'd0, 8'd0);
    end
  endtask

  task automatic test_reset_mid();
    bit rv_seen;
    for (int i = 0; i < NUM_PTS; i++) load_pt(6'(i), 4'($urandom_range(1, 15)), 4'($urandom));
    @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (NUM_PTS) @(negedge clk_i);
    done_i = 1'b1; c1x_i = 4'd5; c1y_i = 4'd6; c2x_i = 4'd7; c2y_i = 4'd8;
    @(negedge clk_i);
    done_i = 1'b0;
    repeat (10) @(negedge clk_i);
    #2 rst_n_i = 1'b0;
    #1;
    total++;
    if ({busy_o, x_o, y_o, pt_valid_o, res_valid_o, score_o, res_c1x_o, res_c1y_o,
         res_c2x_o, res_c2y_o, timeout_o} !== '0) begin
      bad++;
      $display("FAIL reset_mid: got busy=%b rv=%b score=%0d res=%h%h%h%h to=%b, want all 0",
               busy_o, res_valid_o, score_o, res_c1x_o, res_c1y_o, res_c2x_o, res_c2y_o, timeout_o);
    end
    model_clear();
    @(negedge clk_i);
    rst_n_i = 1'b1;
    rv_seen = 1'b0;
    repeat (60) begin
      @(negedge clk_i);
      if (res_valid_o !== 1'b0 || busy_o !== 1'b0) rv_seen = 1'b1;
    end
    total++;
    if (rv_seen) begin
      bad++;
      $display("FAIL reset_no_result: got rv/busy activity after reset, want none");
    end
    run_frame(1'b1, 0, 4'd0, 4'd0, 4'd15, 4'd15, 1'b0, 1'b0, 6'd0, 8'd0);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_cluster();
    test_boundary();
    test_timeout();
    test_disturb();
    test_start_write();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
